// File: rtl/rnf_txreq.sv
// CHI REQ channel transmitter: request FIFO, L-credit tracking and PEND/V sequencing toward the HN-F.
// Optional TxnID allocation at pop is enabled by defining TXREQ_TXNID_ALLOC_EN.
package rnf_txreq_pkg;
   localparam int TXNID_W = 8;

   typedef struct packed {
      logic [3:0]         qos;
      logic [6:0]         tgt_id;
      logic [6:0]         src_id;
      logic [TXNID_W-1:0] txn_id;
      logic [5:0]         opcode;
      logic [2:0]         size;
      logic [47:0]        addr;
   } reqflit_t;
endpackage

module rnf_txreq
   import rnf_txreq_pkg::*;
#(
   parameter int QUEUE_DEPTH = 4,
   parameter int MAX_LCRD    = 4,
   parameter int TXNID_MAX   = 4
) (
   input  logic                           clock,
   input  logic                           reset,
   input  reqflit_t                       req_flit,
   input  logic                           req_valid,
   output logic                           req_ready,
   input  logic                           link_en,
   output reqflit_t                       TXREQFLIT,
   output logic                           TXREQFLITV,
   output logic                           TXREQFLITPEND,
   input  logic                           TXREQLCRDV,
   output logic [$clog2(MAX_LCRD+1)-1:0]  lcrd_count,
   output logic                           lcrd_overflow,
   output logic                           idle
);
   localparam int AW = $clog2(QUEUE_DEPTH);
   localparam int CW = $clog2(MAX_LCRD + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_STREAM, ST_DRAIN} state_t;

   generate
      if (QUEUE_DEPTH < 2 || (1 << AW) != QUEUE_DEPTH) begin : g_bad_depth
         $error("QUEUE_DEPTH must be a power of two and at least 2");
      end
      if (MAX_LCRD < 1 || TXNID_MAX < 1) begin : g_bad_limits
         $error("MAX_LCRD and TXNID_MAX must be at least 1");
      end
   endgenerate

   reqflit_t        mem_q [QUEUE_DEPTH];
   logic [AW:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   lcrd_q, lcrd_d;
   logic            ovf_q, ovf_d;
   reqflit_t        flit_q, flit_d;
   reqflit_t        head;
   state_t          state_q, state_d;
   logic            fifo_empty, fifo_full, push, arm;

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign push       = req_valid & ~fifo_full;
   // A credit arriving this cycle may be spent immediately, so the count never underflows.
   assign arm        = link_en & ~fifo_empty & ((lcrd_q != '0) | TXREQLCRDV);

   // NOTE: FIFO storage is not reset; the pointers alone define which entries are valid.
   always_ff @(posedge clock) begin
      if (push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= req_flit;
      end
   end

`ifdef TXREQ_TXNID_ALLOC_EN
   localparam int TW = (TXNID_MAX > 1) ? $clog2(TXNID_MAX) : 1;
   logic [TW-1:0] txnid_q, txnid_d;

   always_comb begin
      txnid_d = txnid_q;
      if (arm) begin
         txnid_d = (txnid_q == TW'(TXNID_MAX - 1)) ? '0 : txnid_q + TW'(1);
      end
   end

   always_comb begin
      head        = mem_q[rd_ptr_q[AW-1:0]];
      head.txn_id = TXNID_W'(txnid_q);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         txnid_q <= '0;
      end else begin
         txnid_q <= txnid_d;
      end
   end
`else
   assign head = mem_q[rd_ptr_q[AW-1:0]];
`endif

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
      rd_ptr_d = arm  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
      flit_d   = arm  ? head : flit_q;
   end

   always_comb begin
      lcrd_d = lcrd_q;
      ovf_d  = ovf_q;
      if (TXREQLCRDV && !arm) begin
         if (lcrd_q == CW'(MAX_LCRD)) begin
            ovf_d = 1'b1;
         end else begin
            lcrd_d = lcrd_q + CW'(1);
         end
      end else if (!TXREQLCRDV && arm) begin
         lcrd_d = lcrd_q - CW'(1);
      end
   end

   // FSM: state_q holds the phase (PEND/V pattern) chosen in the previous cycle,
   // so this cycle's V follows from whether that phase had PEND high.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         lcrd_q   <= '0;
         ovf_q    <= 1'b0;
         flit_q   <= '0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         lcrd_q   <= lcrd_d;
         ovf_q    <= ovf_d;
         flit_q   <= flit_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE, ST_DRAIN:   state_d = arm ? ST_ARMED  : ST_IDLE;
         ST_ARMED, ST_STREAM: state_d = arm ? ST_STREAM : ST_DRAIN;
         default:             state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      TXREQFLITV    = (state_q == ST_ARMED) || (state_q == ST_STREAM);
      TXREQFLITPEND = arm;
      TXREQFLIT     = flit_q;
      req_ready     = ~fifo_full;
      lcrd_count    = lcrd_q;
      lcrd_overflow = ovf_q;
      idle          = fifo_empty & ~TXREQFLITV & (lcrd_q == CW'(MAX_LCRD));
   end
endmodule

// File: tb/tb_rnf_txreq.sv
// Directed bench for rnf_txreq: a cycle table for credit/FIFO/PEND-V behaviour plus
// hand-written sequences for FIFO full, reset mid-transfer and TxnID handling.
module tb_rnf_txreq;
   import rnf_txreq_pkg::*;

   logic       clock = 1'b0;
   logic       reset;
   reqflit_t   req_flit;
   logic       req_valid;
   logic       req_ready;
   logic       link_en;
   reqflit_t   TXREQFLIT;
   logic       TXREQFLITV;
   logic       TXREQFLITPEND;
   logic       TXREQLCRDV;
   logic [2:0] lcrd_count;
   logic       lcrd_overflow;
   logic       idle;

   int n_checks = 0;
   int n_fail   = 0;

   reqflit_t push_q[$];
   reqflit_t exp_q[$];

   rnf_txreq dut (
      .clock         (clock),
      .reset         (reset),
      .req_flit      (req_flit),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .link_en       (link_en),
      .TXREQFLIT     (TXREQFLIT),
      .TXREQFLITV    (TXREQFLITV),
      .TXREQFLITPEND (TXREQFLITPEND),
      .TXREQLCRDV    (TXREQLCRDV),
      .lcrd_count    (lcrd_count),
      .lcrd_overflow (lcrd_overflow),
      .idle          (idle)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        valid;
      logic [47:0] addr;
      logic        le;
      logic        lc;
      logic        e_ready;
      logic        e_pend;
      logic        e_v;
      logic [47:0] e_addr;
      logic [2:0]  e_cnt;
      logic        e_ovf;
      logic        e_idle;
   } vec_t;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic reqflit_t mk_flit(input logic [47:0] addr, input logic [7:0] tid,
                                        input logic [5:0] op);
      reqflit_t f;
      f        = '0;
      f.addr   = addr;
      f.txn_id = tid;
      f.opcode = op;
      f.src_id = 7'h12;
      f.tgt_id = 7'h03;
      return f;
   endfunction

   function automatic vec_t mk(input logic v, input logic [47:0] a, input logic le,
                               input logic lc, input logic rdy, input logic p,
                               input logic ev, input logic [47:0] ea, input logic [2:0] c,
                               input logic o, input logic i);
      vec_t r;
      r.valid = v;   r.addr = a;    r.le = le;      r.lc = lc;
      r.e_ready = rdy; r.e_pend = p; r.e_v = ev;    r.e_addr = ea;
      r.e_cnt = c;   r.e_ovf = o;   r.e_idle = i;
      return r;
   endfunction

   // Drives link_en/credits high, pushes push_q as space allows and checks every V flit
   // against exp_q in order, within a bounded number of cycles.
   task automatic stream(input bit chk_tid, input int budget);
      int  cyc;
      bit  fired;
      reqflit_t e;
      cyc = 0;
      link_en    = 1'b1;
      TXREQLCRDV = 1'b1;
      while (exp_q.size() != 0 && cyc < budget) begin
         req_valid = (push_q.size() != 0);
         req_flit  = req_valid ? push_q[0] : '0;
         @(negedge clock);
         if (TXREQFLITV) begin
            e = exp_q.pop_front();
            check("stream_addr",   TXREQFLIT.addr,   e.addr);
            check("stream_opcode", TXREQFLIT.opcode, e.opcode);
            check("stream_srcid",  TXREQFLIT.src_id, e.src_id);
            if (chk_tid) check("stream_txnid", TXREQFLIT.txn_id, e.txn_id);
         end
         fired = req_valid && req_ready;
         @(posedge clock); #1;
         if (fired) void'(push_q.pop_front());
         cyc++;
      end
      check("stream_left_unsent", exp_q.size(), 0);
      req_valid  = 1'b0;
      req_flit   = '0;
      link_en    = 1'b0;
      TXREQLCRDV = 1'b0;
   endtask

   vec_t vecs[31];

   initial begin
      reqflit_t f;
      vecs[0]  = mk(0, 0,         0, 1, 1, 0, 0, 0,         0, 0, 0);
      vecs[1]  = mk(0, 0,         0, 1, 1, 0, 0, 0,         1, 0, 0);
      vecs[2]  = mk(0, 0,         0, 1, 1, 0, 0, 0,         2, 0, 0);
      vecs[3]  = mk(0, 0,         0, 1, 1, 0, 0, 0,         3, 0, 0);
      vecs[4]  = mk(0, 0,         0, 0, 1, 0, 0, 0,         4, 0, 1);
      vecs[5]  = mk(1, 48'h100,   1, 0, 1, 0, 0, 0,         4, 0, 1);
      vecs[6]  = mk(1, 48'h140,   1, 0, 1, 1, 0, 0,         4, 0, 0);
      vecs[7]  = mk(1, 48'h180,   1, 0, 1, 1, 1, 48'h100,   3, 0, 0);
      vecs[8]  = mk(0, 0,         1, 0, 1, 1, 1, 48'h140,   2, 0, 0);
      vecs[9]  = mk(0, 0,         1, 0, 1, 0, 1, 48'h180,   1, 0, 0);
      vecs[10] = mk(0, 0,         1, 0, 1, 0, 0, 0,         1, 0, 0);
      vecs[11] = mk(1, 48'h200,   1, 0, 1, 0, 0, 0,         1, 0, 0);
      vecs[12] = mk(1, 48'h240,   1, 0, 1, 1, 0, 0,         1, 0, 0);
      vecs[13] = mk(1, 48'h280,   1, 0, 1, 0, 1, 48'h200,   0, 0, 0);
      vecs[14] = mk(0, 0,         1, 0, 1, 0, 0, 0,         0, 0, 0);
      vecs[15] = mk(0, 0,         1, 1, 1, 1, 0, 0,         0, 0, 0);
      vecs[16] = mk(0, 0,         1, 0, 1, 0, 1, 48'h240,   0, 0, 0);
      vecs[17] = mk(0, 0,         1, 0, 1, 0, 0, 0,         0, 0, 0);
      vecs[18] = mk(0, 0,         0, 1, 1, 0, 0, 0,         0, 0, 0);
      vecs[19] = mk(0, 0,         0, 1, 1, 0, 0, 0,         1, 0, 0);
      vecs[20] = mk(0, 0,         0, 1, 1, 0, 0, 0,         2, 0, 0);
      vecs[21] = mk(0, 0,         0, 1, 1, 0, 0, 0,         3, 0, 0);
      vecs[22] = mk(0, 0,         0, 1, 1, 0, 0, 0,         4, 0, 0);
      vecs[23] = mk(0, 0,         0, 1, 1, 0, 0, 0,         4, 1, 0);
      vecs[24] = mk(0, 0,         0, 0, 1, 0, 0, 0,         4, 1, 0);
      vecs[25] = mk(0, 0,         0, 0, 1, 0, 0, 0,         4, 1, 0);
      vecs[26] = mk(0, 0,         1, 0, 1, 1, 0, 0,         4, 1, 0);
      vecs[27] = mk(0, 0,         0, 0, 1, 0, 1, 48'h280,   3, 1, 0);
      vecs[28] = mk(0, 0,         0, 0, 1, 0, 0, 0,         3, 1, 0);
      vecs[29] = mk(0, 0,         0, 1, 1, 0, 0, 0,         3, 1, 0);
      vecs[30] = mk(0, 0,         0, 0, 1, 0, 0, 0,         4, 1, 1);

      reset      = 1'b1;
      req_flit   = '0;
      req_valid  = 1'b0;
      link_en    = 1'b0;
      TXREQLCRDV = 1'b0;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;

      @(negedge clock);
      check("rst_flit",  TXREQFLIT,     '0);
      check("rst_v",     TXREQFLITV,    1'b0);
      check("rst_pend",  TXREQFLITPEND, 1'b0);
      check("rst_cnt",   lcrd_count,    3'd0);
      check("rst_ready", req_ready,     1'b1);
      @(posedge clock); #1;

      for (int i = 0; i < 31; i++) begin
         req_valid  = vecs[i].valid;
         req_flit   = mk_flit(vecs[i].addr, 8'h00, 6'h00);
         link_en    = vecs[i].le;
         TXREQLCRDV = vecs[i].lc;
         @(negedge clock);
         check($sformatf("row%0d_ready", i), req_ready,     vecs[i].e_ready);
         check($sformatf("row%0d_pend", i),  TXREQFLITPEND, vecs[i].e_pend);
         check($sformatf("row%0d_v", i),     TXREQFLITV,    vecs[i].e_v);
         check($sformatf("row%0d_cnt", i),   lcrd_count,    vecs[i].e_cnt);
         check($sformatf("row%0d_ovf", i),   lcrd_overflow, vecs[i].e_ovf);
         check($sformatf("row%0d_idle", i),  idle,          vecs[i].e_idle);
         if (vecs[i].e_v) check($sformatf("row%0d_addr", i), TXREQFLIT.addr, vecs[i].e_addr);
         @(posedge clock); #1;
      end
      req_valid  = 1'b0;
      req_flit   = '0;
      link_en    = 1'b0;
      TXREQLCRDV = 1'b0;

      // Fill the FIFO with the link disabled, then the fifth request must see ready low.
      for (int i = 0; i < 5; i++) begin
         f = mk_flit(48'h300 + 48'(i) * 48'h40, 8'h00, 6'(i + 1));
         exp_q.push_back(f);
         req_valid = 1'b1;
         req_flit  = f;
         @(negedge clock);
         check($sformatf("fill%0d_ready", i), req_ready, (i < 4) ? 1'b1 : 1'b0);
         check($sformatf("fill%0d_pend", i),  TXREQFLITPEND, 1'b0);
         if (i == 4) push_q.push_back(f);
         else begin
            @(posedge clock); #1;
         end
      end
      stream(1'b0, 40);

      // Reset while a second flit is armed: it must never appear on the link.
      for (int i = 0; i < 2; i++) begin
         req_valid = 1'b1;
         req_flit  = mk_flit(48'h600 + 48'(i) * 48'h40, 8'h00, 6'h0);
         @(posedge clock); #1;
      end
      req_valid  = 1'b0;
      link_en    = 1'b1;
      TXREQLCRDV = 1'b1;
      @(negedge clock);
      check("mid_arm_pend", TXREQFLITPEND, 1'b1);
      @(posedge clock); #1;
      reset = 1'b1;
      @(negedge clock);
      check("mid_first_v",    TXREQFLITV,     1'b1);
      check("mid_first_addr", TXREQFLIT.addr, 48'h600);
      @(posedge clock); #1;
      reset = 1'b0;
      @(negedge clock);
      check("mid_drop_v",    TXREQFLITV,    1'b0);
      check("mid_drop_pend", TXREQFLITPEND, 1'b0);
      check("mid_flit",      TXREQFLIT,     '0);
      check("mid_cnt",       lcrd_count,    3'd0);
      check("mid_ovf",       lcrd_overflow, 1'b0);
      check("mid_ready",     req_ready,     1'b1);
      @(posedge clock); #1;
      @(negedge clock);
      check("mid_after_v",   TXREQFLITV,    1'b0);
      @(posedge clock); #1;
      link_en    = 1'b0;
      TXREQLCRDV = 1'b0;

      // Six flits all tagged 0x55: allocator renumbers them, otherwise they pass through.
      for (int i = 0; i < 6; i++) begin
         f = mk_flit(48'h500 + 48'(i) * 48'h40, 8'h55, 6'(i + 10));
         push_q.push_back(f);
`ifdef TXREQ_TXNID_ALLOC_EN
         f.txn_id = 8'(i % 4);
`endif
         exp_q.push_back(f);
      end
      stream(1'b1, 60);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
